// File: rtl/dmem_responder.sv
// dmem_responder: data-memory bus responder with byte-lane RAM, cycle counter, console TX FIFO and tohost register.
// Define DMEM_MISALIGN_TRAP_EN to suppress misaligned RAM accesses and raise sticky mem_fault instead of force-aligning.
module dmem_responder #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W = 32,
    parameter int FIFO_DEPTH = 8,
    parameter logic [DM_ADDRESS-1:0] MMIO_BASE = 9'h1F0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2:0]            funct3,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready,
    output logic                  halted,
    output logic [7:0]            halt_code,
    output logic                  mem_fault
);
    localparam int RAM_WORDS = int'(MMIO_BASE) / 4;
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [DATA_W-1:0] ram_q [RAM_WORDS];
    logic [7:0]        fifo_q [FIFO_DEPTH];
    logic [DATA_W-1:0] cycle_q, cycle_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              overflow_q, overflow_d, halted_q, halt_code_we;
    logic [7:0]        halt_code_q;
    logic              is_mmio, full, empty, push, push_ok, pop;
    logic [1:0]        rsel;
    logic [DATA_W-1:0] word, ram_rd, ram_rd_v, mmio_rd, status, wlanes;
    logic [7:0]        b;
    logic [15:0]       h;
    logic [3:0]        be, ram_be;
    assign is_mmio = addr >= MMIO_BASE;
    // MMIO_BASE is word-aligned, so the register index is a 2-bit offset from the base word
    assign rsel = addr[3:2] - MMIO_BASE[3:2];
    assign word = ram_q[addr[DM_ADDRESS-1:2]];
    assign b = word[{addr[1:0], 3'b000} +: 8];
    assign h = addr[1] ? word[31:16] : word[15:0];
    assign ram_rd = funct3 == 3'b000 ? {{24{b[7]}}, b} :
                    funct3 == 3'b001 ? {{16{h[15]}}, h} :
                    funct3 == 3'b010 ? word :
                    funct3 == 3'b100 ? {24'b0, b} :
                    funct3 == 3'b101 ? {16'b0, h} : '0;
    assign be = funct3 == 3'b000 ? 4'b0001 << addr[1:0] :
                funct3 == 3'b001 ? (addr[1] ? 4'b1100 : 4'b0011) :
                funct3 == 3'b010 ? 4'b1111 : 4'b0000;
    assign wlanes = funct3[1] ? wr_data : funct3[0] ? {2{wr_data[15:0]}} : {4{wr_data[7:0]}};
`ifdef DMEM_MISALIGN_TRAP_EN
    logic misaligned, mem_fault_q;
    assign misaligned = !is_mmio && ((funct3[1:0] == 2'b01 && addr[0]) ||
                                     (funct3 == 3'b010 && addr[1:0] != 2'b00));
    assign ram_rd_v = misaligned ? '0 : ram_rd;
    assign ram_be = misaligned ? 4'b0000 : be;
    assign mem_fault = mem_fault_q;
    always_ff @(posedge clk) begin
        if (reset) mem_fault_q <= 1'b0;
        else if ((mem_read || mem_write) && misaligned) mem_fault_q <= 1'b1;
    end
`else
    assign ram_rd_v = ram_rd;
    assign ram_be = be;
    assign mem_fault = 1'b0;
`endif
    assign full = count_q == (AW+1)'(FIFO_DEPTH);
    assign empty = count_q == '0;
    assign tx_valid = !reset && !empty;
    assign tx_data = reset ? 8'h00 : fifo_q[rd_ptr_q];
    assign pop = tx_valid && tx_ready;
    assign push = mem_write && is_mmio && rsel == 2'd1;
    assign push_ok = push && (!full || pop);
    assign halt_code_we = mem_write && is_mmio && rsel == 2'd3;
    assign status = 32'({5'(count_q), 1'b0, overflow_q, empty, full});
    assign mmio_rd = rsel == 2'd0 ? cycle_q : rsel == 2'd2 ? status : '0;
    assign rd_data = (mem_read && !mem_write) ? (is_mmio ? mmio_rd : ram_rd_v) : '0;
    assign cycle_d = cycle_q + 1'b1;
    assign wr_ptr_d = wr_ptr_q + AW'(push_ok);
    assign rd_ptr_d = rd_ptr_q + AW'(pop);
    assign count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    assign overflow_d = overflow_q || (push && !push_ok);
    assign halted = halted_q;
    assign halt_code = halt_code_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
            overflow_q <= 1'b0;
            halted_q <= 1'b0;
            halt_code_q <= 8'h00;
        end else begin
            cycle_q <= cycle_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
            overflow_q <= overflow_d;
            if (halt_code_we) begin
                halted_q <= 1'b1;
                halt_code_q <= wr_data[7:0];
            end
        end
    end
    // storage arrays are not cleared by reset
    always_ff @(posedge clk) begin
        if (!reset && push_ok) fifo_q[wr_ptr_q] <= wr_data[7:0];
        if (mem_write && !is_mmio)
            for (int i = 0; i < 4; i++)
                if (ram_be[i]) ram_q[addr[DM_ADDRESS-1:2]][8*i +: 8] <= wlanes[8*i +: 8];
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of RAM loads/stores, console FIFO, CYCLE, TOHOST and reset.
// Misalignment expectations follow DMEM_MISALIGN_TRAP_EN when it is defined.
module tb_dmem_responder;
    logic        clk, reset, mem_read, mem_write, tx_ready;
    logic [8:0]  addr;
    logic [31:0] wr_data, rd_data, c0;
    logic [2:0]  funct3;
    logic        tx_valid, halted, mem_fault;
    logic [7:0]  tx_data, halt_code;
    int checks = 0;
    int failures = 0;

    dmem_responder dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wr_data(wr_data), .funct3(funct3), .rd_data(rd_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .halted(halted), .halt_code(halt_code), .mem_fault(mem_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic r, input logic w, input logic [8:0] a, input logic [31:0] d, input logic [2:0] f);
        mem_read = r;
        mem_write = w;
        addr = a;
        wr_data = d;
        funct3 = f;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        tx_ready = 1'b0;
        req(0, 0, 9'h000, 32'h0, 3'b000);
        step;
        step;
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_halt_code", 32'(halt_code), 32'h0);
        chk("rst_mem_fault", 32'(mem_fault), 32'h0);
        chk("rst_rd_idle", rd_data, 32'h0);
        reset = 1'b0;
        req(0, 1, 9'h010, 32'hDEADBEEF, 3'b010);
        step;
        req(1, 0, 9'h011, 32'h0, 3'b000);
        chk("lb", rd_data, 32'hFFFFFFBE);
        req(1, 0, 9'h011, 32'h0, 3'b100);
        chk("lbu", rd_data, 32'h000000BE);
        req(1, 0, 9'h012, 32'h0, 3'b101);
        chk("lhu", rd_data, 32'h0000DEAD);
        req(1, 0, 9'h012, 32'h0, 3'b001);
        chk("lh", rd_data, 32'hFFFFDEAD);
        req(0, 0, 9'h010, 32'h0, 3'b010);
        chk("no_read_zero", rd_data, 32'h0);
        req(1, 1, 9'h013, 32'h0000005A, 3'b000);
        chk("rw_both_zero", rd_data, 32'h0);
        step;
        req(1, 0, 9'h010, 32'h0, 3'b010);
        chk("sb_lw", rd_data, 32'h5AADBEEF);
        req(0, 1, 9'h010, 32'h00007777, 3'b001);
        step;
        req(1, 0, 9'h010, 32'h0, 3'b010);
        chk("sh_lw", rd_data, 32'h5AAD7777);
        req(0, 1, 9'h010, 32'h11111111, 3'b011);
        step;
        req(1, 0, 9'h010, 32'h0, 3'b011);
        chk("undef_read", rd_data, 32'h0);
        req(1, 0, 9'h010, 32'h0, 3'b010);
        chk("undef_write_suppressed", rd_data, 32'h5AAD7777);
        for (int i = 1; i <= 9; i++) begin
            req(0, 1, 9'h1F4, 32'(i), 3'b010);
            step;
        end
        req(1, 0, 9'h1F8, 32'h0, 3'b010);
        chk("status_full_ovf", rd_data, 32'h00000085);
        req(1, 0, 9'h1F4, 32'h0, 3'b010);
        chk("tx_read_zero", rd_data, 32'h0);
        req(0, 0, 9'h000, 32'h0, 3'b000);
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain1_valid", 32'(tx_valid), 32'h1);
            chk("drain1_data", 32'(tx_data), 32'(i));
            step;
        end
        chk("drain1_empty_valid", 32'(tx_valid), 32'h0);
        req(1, 0, 9'h1F8, 32'h0, 3'b010);
        chk("status_empty_ovf", rd_data, 32'h00000006);
        tx_ready = 1'b0;
        reset = 1'b1;
        step;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req(0, 1, 9'h1F4, 32'h10 + 32'(i), 3'b010);
            step;
        end
        req(1, 0, 9'h1F8, 32'h0, 3'b010);
        chk("status_full", rd_data, 32'h00000081);
        tx_ready = 1'b1;
        req(0, 1, 9'h1F4, 32'h77, 3'b010);
        step;
        tx_ready = 1'b0;
        req(1, 0, 9'h1F8, 32'h0, 3'b010);
        chk("status_push_pop_full", rd_data, 32'h00000081);
        req(0, 0, 9'h000, 32'h0, 3'b000);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain2_data", 32'(tx_data), i < 7 ? 32'h11 + 32'(i) : 32'h77);
            step;
        end
        chk("drain2_empty_valid", 32'(tx_valid), 32'h0);
        req(1, 0, 9'h1F0, 32'h0, 3'b010);
        c0 = rd_data;
        repeat (5) step;
        chk("cycle_delta", rd_data - c0, 32'd5);
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req(0, 1, 9'h1F4, 32'hA1 + 32'(i), 3'b010);
            step;
        end
        req(0, 0, 9'h000, 32'h0, 3'b000);
        tx_ready = 1'b1;
        step;
        chk("middrain_data", 32'(tx_data), 32'hA2);
        reset = 1'b1;
        step;
        chk("inreset_valid", 32'(tx_valid), 32'h0);
        chk("inreset_data", 32'(tx_data), 32'h0);
        reset = 1'b0;
        req(1, 0, 9'h1F0, 32'h0, 3'b010);
        chk("cycle_after_reset", rd_data, 32'h0);
        chk("valid_after_reset", 32'(tx_valid), 32'h0);
        step;
        chk("cycle_after_reset_1", rd_data, 32'h1);
        req(0, 1, 9'h1F8, 32'hFFFFFFFF, 3'b010);
        step;
        req(1, 0, 9'h1F8, 32'h0, 3'b010);
        chk("status_ro", rd_data, 32'h00000002);
        req(0, 1, 9'h1FC, 32'h0000002A, 3'b010);
        chk("halted_before", 32'(halted), 32'h0);
        step;
        req(0, 0, 9'h000, 32'h0, 3'b000);
        chk("halted", 32'(halted), 32'h1);
        chk("halt_code", 32'(halt_code), 32'h2A);
        req(0, 1, 9'h1FC, 32'h00000155, 3'b010);
        step;
        req(0, 0, 9'h000, 32'h0, 3'b000);
        chk("halt_code_update", 32'(halt_code), 32'h55);
        chk("halted_sticky", 32'(halted), 32'h1);
`ifdef DMEM_MISALIGN_TRAP_EN
        req(1, 0, 9'h012, 32'h0, 3'b010);
        chk("mis_lw_zero", rd_data, 32'h0);
        chk("mis_fault_before", 32'(mem_fault), 32'h0);
        step;
        req(0, 1, 9'h011, 32'hFFFFFFFF, 3'b010);
        chk("mis_fault_set", 32'(mem_fault), 32'h1);
        step;
        req(1, 0, 9'h011, 32'h0, 3'b001);
        chk("mis_lh_zero", rd_data, 32'h0);
        req(1, 0, 9'h010, 32'h0, 3'b010);
        chk("mis_sw_suppressed", rd_data, 32'h5AAD7777);
        step;
        chk("mis_fault_held", 32'(mem_fault), 32'h1);
`else
        req(1, 0, 9'h012, 32'h0, 3'b010);
        chk("mis_lw_aligned", rd_data, 32'h5AAD7777);
        req(1, 0, 9'h011, 32'h0, 3'b001);
        chk("mis_lh_aligned", rd_data, 32'h00007777);
        req(0, 1, 9'h013, 32'h01020304, 3'b010);
        step;
        req(1, 0, 9'h010, 32'h0, 3'b010);
        chk("mis_sw_aligned", rd_data, 32'h01020304);
        chk("mis_fault_zero", 32'(mem_fault), 32'h0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
